// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
// Generic inter-stage pipeline buffer (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
// Carries an opaque payload and an exception vector whose MSB has the highest
// priority. Adds a valid/ready handshake, an optional one-entry skid buffer,
// synchronous flush, exception priority encoding and optional input blocking
// after an excepting entry has been accepted.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst          - asynchronous active-high reset
//   in_valid     - upstream entry valid
//   in_ready     - buffer can accept an entry this cycle
//   in_data      - upstream payload
//   in_exc       - upstream exception vector
//   flush        - synchronous flush, discards all contents
//   out_valid    - head entry valid
//   out_ready    - downstream accepts the head entry
//   out_data     - head payload
//   out_exc      - head exception vector
//   out_has_exc  - head entry is valid and carries an exception
//   out_exc_code - index of the highest set bit of out_exc (0 when none)
//   blocked      - block mode active, accepted inputs are being dropped
//   drop_cnt     - saturating count of entries dropped while blocked
module pipe_stage_buf #(
  parameter int DATA_W    = 96,
  parameter int EXC_W     = 9,
  parameter int SKID      = 1,
  parameter int EXC_BLOCK = 1,
  parameter int CNT_W     = 8,
  localparam int CODE_W   = (EXC_W > 1) ? $clog2(EXC_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_has_exc,
  output logic [CODE_W-1:0] out_exc_code,
  output logic              blocked,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [EXC_W-1:0]  main_exc_q,   main_exc_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [EXC_W-1:0]  skid_exc_q,   skid_exc_d;
  logic              blocked_q,    blocked_d;
  logic [CNT_W-1:0]  drop_cnt_q,   drop_cnt_d;

  logic accept;
  logic deliver;
  logic push;
  logic drop;

  // With a skid entry in_ready comes straight from a flop; without one it
  // must look through to out_ready so a full register can still stream.
  always_comb begin
    if (SKID != 0) begin
      in_ready = !skid_valid_q;
    end else begin
      in_ready = !main_valid_q || out_ready;
    end
  end

  assign accept  = in_valid && in_ready;
  assign deliver = main_valid_q && out_ready;
  assign drop    = accept && blocked_q;
  assign push    = accept && !blocked_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_exc_d   = main_exc_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_exc_d   = skid_exc_q;
    blocked_d    = blocked_q;
    drop_cnt_d   = drop_cnt_q;

    if (flush) begin
      // Flush wins over everything; inputs in this cycle are neither stored
      // nor counted as drops.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      blocked_d    = 1'b0;
    end else begin
      if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end

      if ((EXC_BLOCK != 0) && push && (|in_exc)) begin
        blocked_d = 1'b1;
      end

      if (deliver) begin
        // A full skid refills main; in_ready was low so no accept can race it.
        if (skid_valid_q) begin
          main_data_d  = skid_data_q;
          main_exc_d   = skid_exc_q;
          skid_valid_d = 1'b0;
        end else if (push) begin
          main_data_d  = in_data;
          main_exc_d   = in_exc;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (push) begin
        if (!main_valid_q) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
          main_exc_d   = in_exc;
        end else if (SKID != 0) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
          skid_exc_d   = in_exc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_exc_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_exc_q   <= '0;
      blocked_q    <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_exc_q   <= main_exc_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_exc_q   <= skid_exc_d;
      blocked_q    <= blocked_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Ascending scan so the highest set bit is the last one to win.
  always_comb begin
    out_exc_code = '0;
    for (int i = 0; i < EXC_W; i++) begin
      if (main_exc_q[i]) begin
        out_exc_code = i[CODE_W-1:0];
      end
    end
  end

  assign out_valid   = main_valid_q;
  assign out_data    = main_data_q;
  assign out_exc     = main_exc_q;
  assign out_has_exc = main_valid_q && (|main_exc_q);
  assign blocked     = blocked_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic, parametrised inter-stage pipeline buffer for the CPU pipeline (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Carries an opaque payload plus an exception vector using the ExceptinPipeType bit ordering (MSB = Interrupt, highest priority).
- Adds a valid/ready handshake, an optional one-entry skid buffer, synchronous flush, exception priority encoding and optional post-exception input blocking.
- Replaces the hand-written per-stage registers with one block.

Parameters:
- DATA_W, 96: payload width in bits (≥1).
- EXC_W, 9: exception vector width in bits (≥1). Bit EXC_W-1 has the highest priority.
- SKID, 1: 1 = two-entry buffer (main + skid), full throughput with registered in_ready. 0 = single register, in_ready = !out_valid || out_ready (combinational).
- EXC_BLOCK, 1: 1 = after an excepting entry is accepted, later inputs are dropped until flush. 0 = no blocking.
- CNT_W, 8: width of the drop counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  buffer can accept an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_exc  in  EXC_W  upstream exception vector.
- flush  in  1  synchronous flush; discards all contents.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  DATA_W  head payload.
- out_exc  out  EXC_W  head exception vector.
- out_has_exc  out  1  |out_exc (qualified by out_valid).
- out_exc_code  out  $clog2(EXC_W) (minimum 1)  index of the highest set bit of out_exc; 0 when none set.
- blocked  out  1  block mode active.
- drop_cnt  out  CNT_W  saturating count of entries dropped while blocked.

Behaviour:
Reset (async, rst=1):
- out_valid=0, skid valid=0, blocked=0, drop_cnt=0.
- out_data and out_exc = 0.
- in_ready=1.

Handshake and latency:
- Accept = in_valid && in_ready. Deliver = out_valid && out_ready.
- Latency is 1 cycle: an entry accepted at edge N is presented on out_* after edge N.
- Data is never duplicated, reordered or lost except by flush or block-drop.
- out_* are stable while out_valid && !out_ready.

SKID=1:
- in_ready = !skid_valid, registered.
- Accept while the main register holds an entry and !out_ready: the entry goes to skid.
- Deliver while skid is valid: skid moves to main; a simultaneous accept goes to skid only if skid was vacated that cycle, otherwise in_ready=0 prevents the accept.
- Accept with main empty, or with main delivering and skid empty: the entry goes straight to main.
- Sustained in_valid=out_ready=1 gives one entry per cycle.

SKID=0:
- Main register only; in_ready is combinational as defined under Parameters.

Flush:
- Synchronous; has priority over every other event in the same cycle.
- Clears out_valid, skid valid and blocked.
- Any input presented in the flush cycle is discarded and is not counted.
- drop_cnt is not cleared.
- in_ready=1 in the cycle after flush.

Block mode (EXC_BLOCK=1):
- When an entry with |in_exc=1 is accepted, blocked=1 from the next cycle.
- While blocked, in_ready behaves as normal, but each accepted entry is dropped and drop_cnt increments, saturating at 2^CNT_W-1.
- The excepting entry itself is delivered normally.
- Only flush or reset clears blocked.
- With EXC_BLOCK=0, blocked stays 0 permanently.

Priority encoding:
- out_exc_code is combinational from out_exc.
- Example (EXC_W=9): out_exc=9'b1_0000_0001 gives code 8; 9'b0_0010_0100 gives code 5.
- out_has_exc=0 whenever out_valid=0.

Simultaneous events:
- Accept + deliver + skid-valid in one cycle resolves as described under SKID=1.
- Flush overrides accept and deliver; a delivery in the flush cycle still counts as delivered downstream.

Reset mid-operation:
- Contents are lost immediately (asynchronous).
- Outputs take their reset values without waiting for a clock edge.

Test Plan:
1. Streaming: SKID=1, in_valid=out_ready=1 for 10 cycles with payload 0..9 -> out_data 0..9 on consecutive cycles starting 1 cycle later; in_ready stays 1.
2. Backpressure: out_ready=0 while sending payloads 0xA then 0xB -> 0xA held on out_*, 0xB goes to skid, in_ready=0; release out_ready -> 0xA then 0xB delivered, in_ready=1 again.
3. Exception priority and block: send entry with in_exc=9'h021, then three clean entries -> out_exc_code=5 and out_has_exc=1 on the first entry; blocked=1; drop_cnt=3; the three clean entries never appear on out_*.
4. Flush: with main and skid both full, assert flush together with in_valid=1 -> next cycle out_valid=0, blocked=0, in_ready=1; drop_cnt unchanged; the flushed input never appears on out_*.
5. Saturation: CNT_W=2, blocked, 6 further accepts -> drop_cnt reads 3 and holds.
6. Async reset: assert rst mid-cycle while out_valid=1 -> out_valid=0 and out_data=0 before the next clock edge; SKID=0 variant repeats tests 1 and 2 with combinational in_ready.
